// File: rtl/ysyx_24080006_csr_pkg.sv
// Shared definitions for the CSR controller: CSR addresses, mstatus bit positions,
// request opcodes, FSM states and the mstatus trap-entry/return helper.
package ysyx_24080006_csr_pkg;

   localparam logic [11:0] MSTATUS   = 12'h300;
   localparam logic [11:0] MTVEC     = 12'h305;
   localparam logic [11:0] MEPC      = 12'h341;
   localparam logic [11:0] MCAUSE    = 12'h342;
   localparam logic [11:0] MVENDORID = 12'hF11;
   localparam logic [11:0] MARCHID   = 12'hF12;

   localparam int MIE    = 3;
   localparam int MPIE   = 7;
   localparam int MPP_LO = 11;

   typedef enum logic [2:0] {
      OP_CSRRW = 3'd0,
      OP_CSRRS = 3'd1,
      OP_CSRRC = 3'd2,
      OP_ECALL = 3'd3,
      OP_MRET  = 3'd4
   } csr_op_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CSR_WR,
      S_T_MEPC,
      S_T_CAUSE,
      S_T_STAT,
      S_T_VEC,
      S_M_STAT,
      S_M_VEC,
      S_RESP
   } csr_ctrl_state_e;

   function automatic logic csr_supported(input logic [11:0] addr);
      return (addr == MSTATUS) || (addr == MTVEC) || (addr == MEPC) ||
             (addr == MCAUSE) || (addr == MVENDORID) || (addr == MARCHID);
   endfunction

   function automatic logic csr_read_only(input logic [11:0] addr);
      return (addr == MVENDORID) || (addr == MARCHID);
   endfunction

   // is_trap=1: trap entry (stack MIE into MPIE); is_trap=0: mret (restore MIE).
   function automatic logic [31:0] mstatus_update(input logic [31:0] cur,
                                                  input logic        is_trap,
                                                  input logic [1:0]  mpp);
      logic [31:0] nxt;
      nxt = cur;
      if (is_trap) begin
         nxt[MPIE] = cur[MIE];
         nxt[MIE]  = 1'b0;
      end else begin
         nxt[MIE]  = cur[MPIE];
         nxt[MPIE] = 1'b1;
      end
      nxt[MPP_LO+1:MPP_LO] = mpp;
      return nxt;
   endfunction

endpackage

// File: rtl/ysyx_24080006_csr_ctrl.sv
// Sequences CSRRx / ECALL / MRET requests onto the CSR file ports and returns rd or a redirect.
// Latency accept->out_valid: CSRRx 2, ECALL 5, MRET 3, NOP 1; one request in flight, in_ready only in IDLE.
module ysyx_24080006_csr_ctrl
   import ysyx_24080006_csr_pkg::*;
#(
   parameter logic [31:0] ECALL_CAUSE = 32'd11,
   parameter logic [1:0]  MPP_VAL     = 2'b11
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [11:0] in_csr_addr,
   input  logic [31:0] in_src,
   input  logic        in_src_is_zero,
   input  logic [31:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rdata,
   output logic        out_redirect,
   output logic [31:0] out_redirect_pc,
   output logic [11:0] csr_addr,
   input  logic [31:0] csr_rdata,
   output logic        csr_we,
   output logic [11:0] csr_waddr,
   output logic [31:0] csr_wdata,
   output logic        mepc_en,
   output logic [31:0] mepc_val
);

   csr_ctrl_state_e state_q, state_d;
   csr_op_e         op_q;
   logic [11:0]     addr_q;
   logic [31:0]     src_q, pc_q, rdata_q, rpc_q;
   logic            zero_q, redir_q;
   logic [31:0]     new_val;
   logic            wr_ok;
   logic            in_is_csrrx;

   assign in_is_csrrx     = (in_op <= 3'd2);
   assign in_ready        = (state_q == S_IDLE);
   assign out_valid       = (state_q == S_RESP);
   assign out_rdata       = rdata_q;
   assign out_redirect    = redir_q;
   assign out_redirect_pc = rpc_q;
   assign mepc_val        = pc_q & 32'hFFFF_FFFC;

   // rdata_q doubles as the latched old value during CSR_WR.
   always_comb begin
      new_val = src_q;
      case (op_q)
         OP_CSRRS: new_val = rdata_q | src_q;
         OP_CSRRC: new_val = rdata_q & ~src_q;
         default:  new_val = src_q;
      endcase
      wr_ok = csr_supported(addr_q) && !csr_read_only(addr_q) &&
              !(((op_q == OP_CSRRS) || (op_q == OP_CSRRC)) && zero_q);
   end

   always_comb begin
      state_d   = state_q;
      csr_addr  = MSTATUS;
      csr_we    = 1'b0;
      csr_waddr = addr_q;
      csr_wdata = '0;
      mepc_en   = 1'b0;
      case (state_q)
         S_IDLE: begin
            csr_addr = in_csr_addr;
            if (in_valid) begin
               case (in_op)
                  OP_CSRRW, OP_CSRRS, OP_CSRRC: state_d = S_CSR_WR;
                  OP_ECALL:                     state_d = S_T_MEPC;
                  OP_MRET:                      state_d = S_M_STAT;
                  default:                      state_d = S_RESP;
               endcase
            end
         end
         S_CSR_WR: begin
            csr_addr  = addr_q;
            csr_we    = wr_ok;
            csr_wdata = new_val;
            state_d   = S_RESP;
         end
         S_T_MEPC: begin
            mepc_en = 1'b1;
            state_d = S_T_CAUSE;
         end
         S_T_CAUSE: begin
            csr_we    = 1'b1;
            csr_waddr = MCAUSE;
            csr_wdata = ECALL_CAUSE;
            state_d   = S_T_STAT;
         end
         S_T_STAT: begin
            csr_addr  = MSTATUS;
            csr_we    = 1'b1;
            csr_waddr = MSTATUS;
            csr_wdata = mstatus_update(csr_rdata, 1'b1, MPP_VAL);
            state_d   = S_T_VEC;
         end
         S_T_VEC: begin
            csr_addr = MTVEC;
            state_d  = S_RESP;
         end
         S_M_STAT: begin
            csr_addr  = MSTATUS;
            csr_we    = 1'b1;
            csr_waddr = MSTATUS;
            csr_wdata = mstatus_update(csr_rdata, 1'b0, MPP_VAL);
            state_d   = S_M_VEC;
         end
         S_M_VEC: begin
            csr_addr = MEPC;
            state_d  = S_RESP;
         end
         S_RESP: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         op_q    <= OP_CSRRW;
         addr_q  <= '0;
         src_q   <= '0;
         zero_q  <= 1'b0;
         pc_q    <= '0;
         rdata_q <= '0;
         redir_q <= 1'b0;
         rpc_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  op_q    <= csr_op_e'(in_op);
                  addr_q  <= in_csr_addr;
                  src_q   <= in_src;
                  zero_q  <= in_src_is_zero;
                  pc_q    <= in_pc;
                  rdata_q <= (in_is_csrrx && csr_supported(in_csr_addr)) ? csr_rdata : '0;
                  redir_q <= 1'b0;
                  rpc_q   <= '0;
               end
            end
            S_T_VEC: begin
               redir_q <= 1'b1;
               rpc_q   <= csr_rdata & 32'hFFFF_FFFC;
            end
            S_M_VEC: begin
               redir_q <= 1'b1;
               rpc_q   <= csr_rdata;
            end
            default: ;
         endcase
      end
   end

endmodule
